// File: rtl/cjb_serial_sub_v.sv
// Bit-serial WIDTH-bit subtractor (diff = x - y), one bit per clock, LSB first,
// with borrow/overflow/zero flags. Optional clamp on overflow: CJB_SERIAL_SUB_SAT_EN.
module cjb_serial_sub_v #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             zero
);

  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xs, ys, res;
  logic             b, x_msb, y_msb;

  logic             d, b_next, last, accept, ovf_raw;
  logic [WIDTH-1:0] raw, fin;

  // Full-subtractor cell plus the values committed on the final RUN edge.
  always_comb begin
    d       = xs[0] ^ ys[0] ^ b;
    b_next  = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & b);
    raw     = {d, res[WIDTH-1:1]};
    last    = (cnt == CW'(WIDTH - 1));
    accept  = start && (state != RUN);
    ovf_raw = (x_msb != y_msb) && (raw[MSB] != x_msb);
`ifdef CJB_SERIAL_SUB_SAT_EN
    if (ovf_raw) fin = x_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else         fin = raw;
`else
    fin = raw;
`endif
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      xs         <= '0;
      ys         <= '0;
      res        <= '0;
      b          <= 1'b0;
      cnt        <= '0;
      x_msb      <= 1'b0;
      y_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
      zero       <= 1'b0;
    end else if (accept) begin
      xs    <= x;
      ys    <= y;
      b     <= 1'b0;
      cnt   <= '0;
      x_msb <= x[MSB];
      y_msb <= y[MSB];
    end else if (state == RUN) begin
      xs  <= xs >> 1;
      ys  <= ys >> 1;
      res <= raw;
      b   <= b_next;
      cnt <= cnt + 1'b1;
      // Results are published only here, so they hold through any later RUN.
      if (last) begin
        diff       <= fin;
        borrow_out <= b_next;
        ovf        <= ovf_raw;
        zero       <= (fin == '0);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_cjb_serial_sub_v.sv
// Scoreboard bench for cjb_serial_sub_v (WIDTH=16); honours CJB_SERIAL_SUB_SAT_EN.
module tb_cjb_serial_sub_v;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic        busy, done, borrow_out, ovf, zero;
  logic [15:0] diff;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] last_diff = '0;

  cjb_serial_sub_v #(.WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
    .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] s);
    exp_t e;
    e.diff   = a - s;
    e.borrow = (a < s);
    e.ovf    = (a[15] != s[15]) && (e.diff[15] != a[15]);
`ifdef CJB_SERIAL_SUB_SAT_EN
    if (e.ovf) e.diff = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    e.zero = (e.diff == 16'h0000);
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge of the first RUN cycle.
  task automatic start_op(input logic [15:0] a, input logic [15:0] s);
    sb.push_back(model(a, s));
    x = a;
    y = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat, output int busy_cycles);
    lat = from;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic pop_compare(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb_empty: no expected entry queued", name);
      return;
    end
    e = sb.pop_front();
    last_diff = e.diff;
    checks += 5;
    if (diff !== e.diff) begin
      errors++; $display("FAIL %s_diff: got %h, required %h", name, diff, e.diff);
    end
    if (borrow_out !== e.borrow) begin
      errors++; $display("FAIL %s_borrow: got %b, required %b", name, borrow_out, e.borrow);
    end
    if (ovf !== e.ovf) begin
      errors++; $display("FAIL %s_ovf: got %b, required %b", name, ovf, e.ovf);
    end
    if (zero !== e.zero) begin
      errors++; $display("FAIL %s_zero: got %b, required %b", name, zero, e.zero);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s_busy_at_done: got %b, required 0", name, busy);
    end
  endtask

  task automatic run_one(input logic [15:0] a, input logic [15:0] s, input string name);
    int lat, bc;
    start_op(a, s);
    wait_done(1, lat, bc);
    pop_compare(name);
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, diff, borrow_out, ovf, zero} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h b=%b o=%b z=%b, required all 0",
               busy, done, diff, borrow_out, ovf, zero);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bc;
    start_op(16'd5, 16'd3);
    wait_done(1, lat, bc);
    checks += 2;
    if (lat !== 17) begin
      errors++; $display("FAIL basic_latency: got %0d, required 17", lat);
    end
    if (bc !== 16) begin
      errors++; $display("FAIL basic_busy_cycles: got %0d, required 16", bc);
    end
    pop_compare("basic");
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: got %b, required 0", done);
    end
  endtask

  task automatic test_borrow_zero;
    run_one(16'd3, 16'd5, "borrow");
    run_one(16'h1234, 16'h1234, "equal");
  endtask

  task automatic test_overflow;
    run_one(16'h8000, 16'h0001, "ovf_neg");
    run_one(16'h7FFF, 16'hFFFF, "ovf_pos");
  endtask

  task automatic test_ignore_start;
    int lat, bc;
    start_op(16'd9, 16'd4);
    repeat (4) @(negedge clk);
    checks++;
    if (diff !== last_diff) begin
      errors++; $display("FAIL hold_during_run: got %h, required %h", diff, last_diff);
    end
    x = 16'd1;
    y = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat, bc);
    checks++;
    if (lat !== 17) begin
      errors++; $display("FAIL ignore_latency: got %0d, required 17", lat);
    end
    pop_compare("ignore_start");
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    start_op(16'd20, 16'd8);
    wait_done(1, lat, bc);
    pop_compare("b2b_first");
    start_op(16'd10, 16'd3);
    wait_done(1, lat, bc);
    checks += 2;
    if (lat !== 17) begin
      errors++; $display("FAIL b2b_latency: got %0d, required 17", lat);
    end
    if (bc !== 16) begin
      errors++; $display("FAIL b2b_busy_cycles: got %0d, required 16", bc);
    end
    pop_compare("b2b_second");
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    start_op(16'h00FF, 16'h0001);
    repeat (7) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midreset_busy_before: got %b, required 1", busy);
    end
    resetn = 1'b0;
    @(negedge clk);
    sb.delete();
    checks++;
    if ({busy, done, diff, borrow_out, ovf, zero} !== 21'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b done=%b diff=%h b=%b o=%b z=%b, required all 0",
               busy, done, diff, borrow_out, ovf, zero);
    end
    resetn = 1'b1;
    @(negedge clk);
    run_one(16'd100, 16'd58, "after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_borrow_zero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
